// File: rtl/err_detect_8b10b.sv
// err_detect_8b10b: receive-side 8b/10b lane checker.
// Flags per-symbol code violations and running-disparity violations, tracks
// link lock with a two-state HUNT/LOCKED machine, and (optionally) counts
// errored words seen while locked.
// Optional feature macro: ERR_DET_STATS_EN enables err_cnt / err_sticky;
// without it both outputs are tied to zero and clr is ignored.
module err_detect_8b10b #(
    parameter int LANES      = 8,
    parameter int LOCK_WORDS = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  valid_in,
    input  logic [10*LANES-1:0]   din,
    output logic                  valid_out,
    output logic [LANES-1:0]      err_mask,
    output logic                  code_err,
    output logic                  disp_err,
    output logic                  locked,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_WORDS);
    localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(ERR_LIMIT);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Number of ones in a vector of up to 6 bits.
    function automatic logic [3:0] ones6(input logic [5:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Classify one symbol: {code_error, total ones}.
    function automatic logic [4:0] classify(input logic [9:0] s);
        logic [3:0] n6;
        logic [3:0] n4;
        logic [3:0] n;
        logic       bad;
        n6  = ones6(s[9:4]);
        n4  = ones6({2'b00, s[3:0]});
        n   = n6 + n4;
        bad = (n6 < 4'd2) || (n6 > 4'd4) ||
              (n4 < 4'd1) || (n4 > 4'd3) ||
              (n  < 4'd4) || (n  > 4'd6);
        return {bad, n};
    endfunction

    // ---------------- stage 0 -> 1: per-lane ones count and code check
    logic [LANES-1:0][3:0] n_s0;
    logic [LANES-1:0]      cerr_s0;
    logic [LANES-1:0][3:0] n_p1;
    logic [LANES-1:0]      cerr_p1;
    logic                  vld_p1;

    // Classify every lane of the incoming word in parallel.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            {cerr_s0[i], n_s0[i]} = classify(din[10*i +: 10]);
        end
    end

    // Stage-1 valid flag; cleared by reset so in-flight words are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= valid_in;
        end
    end

    // Stage-1 data; only loaded for real words so bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (en && valid_in) begin
            n_p1    <= n_s0;
            cerr_p1 <= cerr_s0;
        end
    end

    // ---------------- stage 1 -> 2: serial RD chain, flags, lock FSM
    state_t           state_q;
    state_t           state_n;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_n;
    logic [BAD_W-1:0]  bad_q;
    logic [BAD_W-1:0]  bad_n;
    logic             rd_q;      // 1 = RD+, 0 = RD-
    logic             rd_s1;
    logic [LANES-1:0] derr_s1;
    logic [LANES-1:0] mask_s1;
    logic             word_err_s1;
    logic             word_adv;
    logic             rd_check;

    assign word_adv = en && vld_p1;
    assign rd_check = (state_q == LOCKED);

    // Walk lanes in stream order; code-error lanes neither check nor move RD,
    // and a violation still resyncs RD to the symbol's own ending disparity.
    always_comb begin
        rd_s1   = rd_q;
        derr_s1 = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!cerr_p1[i]) begin
                if (n_p1[i] == 4'd6) begin
                    if (rd_check && rd_s1) begin
                        derr_s1[i] = 1'b1;
                    end
                    rd_s1 = 1'b1;
                end else if (n_p1[i] == 4'd4) begin
                    if (rd_check && !rd_s1) begin
                        derr_s1[i] = 1'b1;
                    end
                    rd_s1 = 1'b0;
                end
            end
        end
    end

    assign mask_s1     = cerr_p1 | derr_s1;
    assign word_err_s1 = |mask_s1;

    // Stored running disparity; reset to RD-.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= 1'b0;
        end else if (word_adv) begin
            rd_q <= rd_s1;
        end
    end

    // Result outputs; hold their last value across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            err_mask  <= '0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
        end else if (en) begin
            valid_out <= vld_p1;
            if (vld_p1) begin
                err_mask <= mask_s1;
                code_err <= |cerr_p1;
                disp_err <= |derr_s1;
            end
        end
    end

    // Lock FSM state and its good/bad word counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_n;
            good_q  <= good_n;
            bad_q   <= bad_n;
        end
    end

    // Lock FSM next state; evaluated only when a real word leaves stage 1.
    always_comb begin
        state_n = state_q;
        good_n  = good_q;
        bad_n   = bad_q;
        if (word_adv) begin
            case (state_q)
                HUNT: begin
                    if (word_err_s1) begin
                        good_n = '0;
                    end else begin
                        good_n = good_q + 1'b1;
                    end
                    if (good_n == GOOD_TGT) begin
                        state_n = LOCKED;
                        bad_n   = '0;
                    end
                end
                LOCKED: begin
                    if (word_err_s1) begin
                        bad_n = bad_q + 1'b1;
                    end else begin
                        bad_n = '0;
                    end
                    if (bad_n == BAD_TGT) begin
                        state_n = HUNT;
                        good_n  = '0;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef ERR_DET_STATS_EN
    // Saturating increment for the error counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic cnt_inc;
    assign cnt_inc = word_adv && (state_q == LOCKED) && word_err_s1;

    // Error statistics; clr wins over a same-cycle increment and works while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (cnt_inc) begin
            err_cnt    <= sat_inc(err_cnt);
            err_sticky <= 1'b1;
        end
    end
`else
    logic clr_unused;
    assign clr_unused = clr;
    assign err_cnt    = '0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_err_detect_8b10b.sv
// Testbench for err_detect_8b10b: hand-derived vector table, directed
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_err_detect_8b10b;

    localparam int LANES      = 8;
    localparam int LOCK_WORDS = 4;
    localparam int ERR_LIMIT  = 3;
    localparam int CNT_W      = 16;
    localparam int W          = 10 * LANES;
`ifdef ERR_DET_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [9:0] SYM_N   = 10'h274;  // D0.0, neutral
    localparam logic [9:0] SYM_KM  = 10'h0FA;  // K28.5 RD-, six ones
    localparam logic [9:0] SYM_KP  = 10'h305;  // K28.5 RD+, four ones
    localparam logic [9:0] SYM_BAD = 10'h270;  // 4b sub-block with no ones

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             valid_in;
    logic [W-1:0]     din;
    logic             valid_out;
    logic [LANES-1:0] err_mask;
    logic             code_err;
    logic             disp_err;
    logic             locked;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;

    err_detect_8b10b #(
        .LANES(LANES), .LOCK_WORDS(LOCK_WORDS), .ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .valid_in(valid_in), .din(din),
        .valid_out(valid_out), .err_mask(err_mask), .code_err(code_err),
        .disp_err(disp_err), .locked(locked), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit           m_pv;
    logic [W-1:0] m_pw;
    bit           m_vo;
    logic [7:0]   m_mask;
    bit           m_code, m_disp, m_locked, m_sticky;
    int           m_good, m_bad, m_rd, m_cnt;

    typedef struct {
        logic [W-1:0] din;
        logic [7:0]   mask;
        logic         code;
        logic         disp;
        logic         lock;
        int           cnt;
        logic         sticky;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] all_lanes(input logic [9:0] s);
        return {LANES{s}};
    endfunction

    function automatic logic [W-1:0] with_lane(input logic [W-1:0] w, input int l, input logic [9:0] s);
        logic [W-1:0] r;
        r = w;
        r[10*l +: 10] = s;
        return r;
    endfunction

    // Apply the checker's rules to one word that reaches the output.
    task automatic model_word(input logic [W-1:0] w);
        logic [9:0] s;
        int n6, n4, n, want;
        m_mask = '0;
        m_code = 1'b0;
        m_disp = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s  = w[10*i +: 10];
            n6 = $countones(s[9:4]);
            n4 = $countones(s[3:0]);
            n  = n6 + n4;
            if (n6 < 2 || n6 > 4 || n4 < 1 || n4 > 3 || n < 4 || n > 6) begin
                m_mask[i] = 1'b1;
                m_code    = 1'b1;
            end else if (n != 5) begin
                want = (n == 6) ? -1 : 1;   // RD this symbol must start from
                if (m_locked && m_rd != want) begin
                    m_mask[i] = 1'b1;
                    m_disp    = 1'b1;
                end
                m_rd = -want;
            end
        end
        if (m_locked) begin
            if (m_mask != 0) begin
                if (STATS) begin
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    m_sticky = 1'b1;
                end
                m_bad++;
                if (m_bad == ERR_LIMIT) begin
                    m_locked = 1'b0;
                    m_good   = 0;
                end
            end else begin
                m_bad = 0;
            end
        end else begin
            if (m_mask != 0) m_good = 0;
            else m_good++;
            if (m_good == LOCK_WORDS) begin
                m_locked = 1'b1;
                m_bad    = 0;
            end
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit c, input bit v, input logic [W-1:0] d);
        if (!r) begin
            m_pv = 0; m_vo = 0; m_mask = '0; m_code = 0; m_disp = 0; m_locked = 0;
            m_good = 0; m_bad = 0; m_rd = -1; m_cnt = 0; m_sticky = 0;
            return;
        end
        if (e) begin
            m_vo = m_pv;
            if (m_pv) model_word(m_pw);
            m_pv = v;
            if (v) m_pw = d;
        end
        if (STATS && c) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit v, input logic [W-1:0] d);
        rst_n = r; en = e; clr = c; valid_in = v; din = d;
        @(posedge clk);
        model_edge(r, e, c, v, d);
        #1;
        check("model",
              64'({valid_out, err_mask, code_err, disp_err, locked, err_sticky, err_cnt}),
              64'({m_vo, m_mask, m_code, m_disp, m_locked, m_sticky, CNT_W'(m_cnt)}));
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] d, input logic [7:0] mask,
                           input logic code, input logic disp, input logic lock,
                           input int cnt, input logic sticky);
        tbl[i].din = d; tbl[i].mask = mask; tbl[i].code = code; tbl[i].disp = disp;
        tbl[i].lock = lock; tbl[i].cnt = cnt; tbl[i].sticky = sticky;
    endtask

    initial begin
        logic [W-1:0] w_n, w_alt, w_e3, w;
        logic [9:0]   sym;
        int           pick;
        bit           r, e, c, v;

        w_n  = all_lanes(SYM_N);
        w_e3 = with_lane(w_n, 3, SYM_BAD);
        w_alt = '0;
        for (int l = 0; l < LANES; l++) w_alt = with_lane(w_alt, l, (l % 2) ? SYM_KP : SYM_KM);

        for (int i = 0; i < 3; i++) set_vec(i, w_n, 8'h00, 0, 0, 0, 0, 0);
        set_vec(3, w_n, 8'h00, 0, 0, 1, 0, 0);
        for (int i = 4; i < 14; i++) set_vec(i, w_alt, 8'h00, 0, 0, 1, 0, 0);
        set_vec(14, w_e3, 8'h08, 1, 0, 1, 1, 1);
        set_vec(15, with_lane(w_n, 0, SYM_KP), 8'h01, 0, 1, 1, 2, 1);
        set_vec(16, w_n, 8'h00, 0, 0, 1, 2, 1);
        set_vec(17, w_e3, 8'h08, 1, 0, 1, 3, 1);
        set_vec(18, w_e3, 8'h08, 1, 0, 1, 4, 1);
        set_vec(19, w_e3, 8'h08, 1, 0, 0, 5, 1);
        set_vec(20, w_e3, 8'h08, 1, 0, 0, 5, 1);

        // reset
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        check("reset_state",
              64'({valid_out, err_mask, code_err, disp_err, locked, err_sticky, err_cnt}), 64'd0);

        // vector table, back-to-back words
        for (int j = 0; j <= NV; j++) begin
            if (j < NV) step(1, 1, 0, 1, tbl[j].din);
            else        step(1, 1, 0, 0, '0);
            if (j == 0) begin
                check("first_latency", 64'(valid_out), 64'd0);
            end else begin
                check($sformatf("vec%0d_flags", j - 1),
                      64'({valid_out, err_mask, code_err, disp_err, locked}),
                      64'({1'b1, tbl[j-1].mask, tbl[j-1].code, tbl[j-1].disp, tbl[j-1].lock}));
                check($sformatf("vec%0d_stats", j - 1),
                      64'({err_sticky, err_cnt}),
                      64'({tbl[j-1].sticky & STATS, STATS ? CNT_W'(tbl[j-1].cnt) : CNT_W'(0)}));
            end
        end

        // stall: en low freezes the pipeline, outputs hold, clr still honoured
        step(1, 1, 0, 1, w_alt);
        check("bubble_out", 64'(valid_out), 64'd0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, w_e3);
        check("stall_hold", 64'({valid_out, err_mask}), 64'({1'b0, 8'h08}));
        step(1, 0, 1, 0, '0);
        check("clr_while_stalled", 64'({err_sticky, err_cnt}), 64'd0);
        step(1, 1, 0, 0, '0);
        check("stall_resume", 64'({valid_out, err_mask}), 64'({1'b1, 8'h00}));
        step(1, 1, 0, 0, '0);

        // relock, then clr coinciding with a counted error
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1, w_n);
        step(1, 1, 0, 1, w_e3);
        step(1, 1, 1, 1, w_n);
        check("clr_vs_error", 64'({valid_out, err_mask, locked, err_sticky, err_cnt}),
              64'({1'b1, 8'h08, 1'b1, 1'b0, CNT_W'(0)}));
        step(1, 1, 0, 1, w_e3);
        step(1, 1, 0, 0, '0);
        check("count_after_clr", 64'({err_mask, err_sticky, err_cnt}),
              64'({8'h08, STATS, STATS ? CNT_W'(1) : CNT_W'(0)}));

        // reset mid-stream discards in-flight words
        step(1, 1, 0, 1, w_n);
        step(1, 1, 0, 1, w_n);
        step(0, 1, 0, 1, w_n);
        check("midreset", 64'({valid_out, locked, err_cnt}), 64'd0);
        step(1, 1, 0, 0, '0);
        check("no_valid_after_reset", 64'(valid_out), 64'd0);
        step(1, 1, 0, 1, w_e3);
        step(1, 1, 0, 0, '0);
        check("hunt_code_err", 64'({valid_out, err_mask, code_err, locked, err_cnt}),
              64'({1'b1, 8'h08, 1'b1, 1'b0, CNT_W'(0)}));

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 5) begin
                w = w_n;
            end else begin
                w = '0;
                for (int l = 0; l < LANES; l++) begin
                    pick = $urandom_range(0, 9);
                    if (pick < 4)       sym = SYM_N;
                    else if (pick < 6)  sym = SYM_KM;
                    else if (pick < 8)  sym = SYM_KP;
                    else if (pick == 8) sym = SYM_BAD;
                    else                sym = 10'($urandom);
                    w = with_lane(w, l, sym);
                end
            end
            r = ($urandom_range(0, 499) != 0);
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 7) != 0);
            step(r, e, c, v, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
